// File: rtl/apb_arb_pkg.sv
// Shared types, default parameters and the round-robin pick function for the
// APB round-robin master arbiter.
package apb_arb_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} apb_state_e;

  localparam int NUM_REQ_DEF     = 2;
  localparam int ADDR_W_DEF      = 32;
  localparam int DATA_W_DEF      = 32;
  localparam int TIMEOUT_CYC_DEF = 16;

  // Upper bound on requesters; the pick function works on vectors of this size.
  localparam int MAX_REQ   = 8;
  localparam int IDX_W_MAX = 3;

  // Returns the first valid index after ptr, searching cyclically over n entries.
  // With nothing valid the pointer itself is returned.
  function automatic logic [IDX_W_MAX-1:0] rr_pick(
    input logic [MAX_REQ-1:0]   valid,
    input logic [IDX_W_MAX-1:0] ptr,
    input int                   n
  );
    logic [IDX_W_MAX-1:0] pick;
    int                   cand;
    pick = ptr;
    // Walk from farthest to nearest so the nearest valid index is written last.
    for (int k = MAX_REQ; k > 0; k--) begin
      if (k <= n) begin
        cand = (int'(ptr) + k) % n;
        if (valid[cand]) pick = IDX_W_MAX'(cand);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/apb_rr_master_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant and index of the first valid
// requester after the pointer.
module rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]         valid,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  logic [MAX_REQ-1:0]   valid_ext;
  logic [IDX_W_MAX-1:0] pick;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    valid_ext          = '0;
    valid_ext[N-1:0]   = valid;
    pick               = rr_pick(valid_ext, IDX_W_MAX'(ptr), N);
    idx                = IW'(pick);
    any                = |valid;
    grant              = '0;
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/apb_rr_master_arbiter.sv
// Round-robin arbiter sharing one APB3 master port between NUM_REQ requesters.
// Optional ACCESS-phase timeout is enabled with the APB_ARB_TIMEOUT_EN macro.
module apb_rr_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ     = NUM_REQ_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                       PCLK,
  input  logic                       PRESETn,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       rsp_err,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  output logic [ADDR_W-1:0]          PADDR,
  output logic [DATA_W-1:0]          PWDATA,
  input  logic [DATA_W-1:0]          PRDATA,
  input  logic                       PREADY
);

  localparam int IDX_W = $clog2(NUM_REQ);

  apb_state_e         state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   owner_q;
  logic [IDX_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic               any_valid;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] tmo_cnt_q;
`else
  assign rsp_err = 1'b0;
`endif

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .valid (req_valid),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (grant_idx),
    .any   (any_valid)
  );

  // Acceptance is visible in the IDLE cycle itself and forced low while in reset.
  assign req_ready = (PRESETn && state_q == ST_IDLE) ? grant : '0;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // in this block samples the pre-edge values of the others.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= ST_IDLE;
      ptr_q     <= IDX_W'(NUM_REQ - 1);
      owner_q   <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_rdata <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      rsp_err   <= 1'b0;
      tmo_cnt_q <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      rsp_err   <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (any_valid) begin
            PWRITE  <= req_write[grant_idx];
            PADDR   <= req_addr[grant_idx*ADDR_W +: ADDR_W];
            PWDATA  <= req_wdata[grant_idx*DATA_W +: DATA_W];
            ptr_q   <= grant_idx;
            owner_q <= grant_idx;
            PSEL    <= 1'b1;
            state_q <= ST_SETUP;
`ifdef APB_ARB_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
          end
        end
        ST_SETUP: begin
          PENABLE <= 1'b1;
          state_q <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (PREADY) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_id    <= owner_q;
            rsp_rdata <= PWRITE ? '0 : PRDATA;
            state_q   <= ST_IDLE;
          end
`ifdef APB_ARB_TIMEOUT_EN
          // A PREADY on the limit cycle takes the branch above and completes normally.
          else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_id    <= owner_q;
            rsp_err   <= 1'b1;
            state_q   <= ST_IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rr_master_arbiter.sv
// Self-checking bench for apb_rr_master_arbiter: vector table, directed corner
// sequences and a randomized run against a transaction-level reference model.
module tb_apb_rr_master_arbiter;
  import apb_arb_pkg::*;

  localparam int N   = 3;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;
  localparam int IW  = $clog2(N);

  logic            PCLK = 1'b0;
  logic            PRESETn;
  logic [N-1:0]    req_valid, req_write, req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic            rsp_valid, rsp_err;
  logic [IW-1:0]   rsp_id;
  logic [DW-1:0]   rsp_rdata;
  logic            PSEL, PENABLE, PWRITE, PREADY;
  logic [AW-1:0]   PADDR;
  logic [DW-1:0]   PWDATA, PRDATA;

  apb_rr_master_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge PCLK);
    #1;
    cyc++;
  endtask

  task automatic sample();
    @(negedge PCLK);
  endtask

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] r;
    r    = '0;
    r[g] = 1'b1;
    return r;
  endfunction

  function automatic logic [DW-1:0] slave_data(input logic [AW-1:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h3C3C_5A5A;
  endfunction

  task automatic clear_reqs();
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]          = 1'b1;
    req_write[i]          = w;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".req_ready"}, req_ready, 0);
    check({tag, ".rsp_valid"}, rsp_valid, 0);
    check({tag, ".rsp_id"},    rsp_id,    0);
    check({tag, ".rsp_rdata"}, rsp_rdata, 0);
    check({tag, ".rsp_err"},   rsp_err,   0);
    check({tag, ".psel"},      PSEL,      0);
    check({tag, ".penable"},   PENABLE,   0);
    check({tag, ".pwrite"},    PWRITE,    0);
    check({tag, ".paddr"},     PADDR,     0);
    check({tag, ".pwdata"},    PWDATA,    0);
  endtask

  task automatic do_reset();
    tick();
    PRESETn = 1'b0;
    clear_reqs();
    req_valid[0] = 1'b1;
    PREADY = 1'b0;
    PRDATA = '0;
    sample();
    check_all_zero("reset");
    tick();
    clear_reqs();
    PRESETn = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [N-1:0]  mask;
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] prdata;
    int            exp_g;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t tbl[9];

  // Requester i offers addr + i*0x100 and wdata ^ i, so a wrong mux select is visible.
  task automatic run_vec(input vec_t v, input string tag);
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    ea = v.addr + AW'(v.exp_g * 256);
    ed = v.wdata ^ DW'(v.exp_g);
    tick();
    for (int i = 0; i < N; i++)
      if (v.mask[i]) set_req(i, v.write, v.addr + AW'(i * 256), v.wdata ^ DW'(i));
    PREADY = 1'b1;
    PRDATA = v.prdata;
    sample();
    check({tag, ".ready"}, req_ready, onehot(v.exp_g));
    check({tag, ".idle_psel"}, PSEL, 0);
    tick();
    clear_reqs();
    sample();
    check({tag, ".setup_psel"},    PSEL,    1);
    check({tag, ".setup_penable"}, PENABLE, 0);
    check({tag, ".setup_paddr"},   PADDR,   ea);
    check({tag, ".setup_pwrite"},  PWRITE,  v.write);
    check({tag, ".setup_pwdata"},  PWDATA,  ed);
    tick();
    sample();
    check({tag, ".access_psel"},    PSEL,    1);
    check({tag, ".access_penable"}, PENABLE, 1);
    check({tag, ".access_pwrite"},  PWRITE,  v.write);
    check({tag, ".access_rspv"},    rsp_valid, 0);
    tick();
    sample();
    check({tag, ".rsp_valid"}, rsp_valid, 1);
    check({tag, ".rsp_id"},    rsp_id,    v.exp_g);
    check({tag, ".rsp_rdata"}, rsp_rdata, v.exp_rdata);
    check({tag, ".rsp_err"},   rsp_err,   0);
    check({tag, ".rsp_psel"},  PSEL,      0);
  endtask

  // ---------------- random-run reference model ----------------
  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  cmd_t          cmds[N];
  bit            has_cmd[N];
  cmd_t          cur;
  int            cur_id, last_g, t_acc, zero_cnt, due_id;
  bit            busy, rsp_due, next_due, due_err;
  logic [DW-1:0] due_rdata;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int            got;
    int            ids[6];
    int            at[6];
    int            g;
    logic [N-1:0]  exp_ready;

    PRESETn = 1'b0;
    clear_reqs();
    PREADY = 1'b0;
    PRDATA = '0;

    tbl[0] = '{3'b001, 1'b1, 32'h10,  32'hDEADBEEF, 32'hFFFF0000, 0, 32'h0};
    tbl[1] = '{3'b001, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 0, 32'hDEADBEEF};
    tbl[2] = '{3'b111, 1'b0, 32'h20,  32'h5,        32'h11111111, 1, 32'h11111111};
    tbl[3] = '{3'b111, 1'b0, 32'h30,  32'h6,        32'h22222222, 2, 32'h22222222};
    tbl[4] = '{3'b111, 1'b1, 32'h40,  32'hA0A0A0A0, 32'h99999999, 0, 32'h0};
    tbl[5] = '{3'b101, 1'b0, 32'h50,  32'h7,        32'h33333333, 2, 32'h33333333};
    tbl[6] = '{3'b110, 1'b0, 32'h60,  32'h8,        32'h44444444, 1, 32'h44444444};
    tbl[7] = '{3'b010, 1'b0, 32'h70,  32'h9,        32'h55555555, 1, 32'h55555555};
    tbl[8] = '{3'b011, 1'b1, 32'h80,  32'hB0B0B0B0, 32'h66666666, 0, 32'h0};

    do_reset();
    for (int v = 0; v < 9; v++) run_vec(tbl[v], $sformatf("vec%0d", v));

    // Two requesters held valid: alternating grants, one every 3 cycles.
    do_reset();
    tick();
    set_req(0, 1'b1, 32'h1000, 32'h1);
    set_req(1, 1'b1, 32'h2000, 32'h2);
    PREADY = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      sample();
      if (req_ready != '0) begin
        ids[got] = (req_ready == 3'b010) ? 1 : (req_ready == 3'b100) ? 2 : (req_ready == 3'b001) ? 0 : 9;
        at[got]  = cyc;
        got++;
      end
      tick();
    end
    clear_reqs();
    check("rr.grant_count", got, 6);
    for (int k = 0; k < got; k++) begin
      check($sformatf("rr.grant%0d", k), ids[k], k % 2);
      if (k > 0) check($sformatf("rr.spacing%0d", k), at[k] - at[k-1], 3);
    end
    repeat (4) tick();

    // Three wait states: command outputs stable, response one cycle after PREADY.
    tick();
    set_req(1, 1'b1, 32'h200, 32'hCAFEF00D);
    PREADY = 1'b0;
    sample();
    check("wait.ready", req_ready, 3'b010);
    tick();
    clear_reqs();
    sample();
    for (int w = 0; w < 3; w++) begin
      tick();
      sample();
      check("wait.psel",    PSEL,      1);
      check("wait.penable", PENABLE,   1);
      check("wait.paddr",   PADDR,     32'h200);
      check("wait.pwdata",  PWDATA,    32'hCAFEF00D);
      check("wait.rspv",    rsp_valid, 0);
    end
    tick();
    PREADY = 1'b1;
    sample();
    check("wait.last_paddr", PADDR,     32'h200);
    check("wait.last_rspv",  rsp_valid, 0);
    tick();
    PREADY = 1'b0;
    sample();
    check("wait.rsp_valid", rsp_valid, 1);
    check("wait.rsp_id",    rsp_id,    1);
    check("wait.rsp_err",   rsp_err,   0);
    check("wait.psel_drop", PSEL,      0);
    tick();
    sample();
    check("wait.rsp_pulse", rsp_valid, 0);

    // PREADY stuck low.
    tick();
    set_req(0, 1'b0, 32'h300, 32'h0);
    PRDATA = 32'h0000_0055;
    sample();
    check("stuck.ready", req_ready, 3'b001);
    tick();
    clear_reqs();
    sample();
`ifdef APB_ARB_TIMEOUT_EN
    for (int w = 0; w < TMO; w++) begin
      tick();
      sample();
      check("tmo.penable", PENABLE,   1);
      check("tmo.rspv",    rsp_valid, 0);
    end
    tick();
    sample();
    check("tmo.rsp_valid", rsp_valid, 1);
    check("tmo.rsp_err",   rsp_err,   1);
    check("tmo.rsp_rdata", rsp_rdata, 0);
    check("tmo.rsp_id",    rsp_id,    0);
    check("tmo.psel",      PSEL,      0);
    check("tmo.penable0",  PENABLE,   0);
    run_vec('{3'b001, 1'b0, 32'h310, 32'h0, 32'h77, 0, 32'h77}, "tmo_next");
`else
    for (int w = 0; w < 20; w++) begin
      tick();
      sample();
      check("stuck.penable", PENABLE,   1);
      check("stuck.rspv",    rsp_valid, 0);
      check("stuck.err",     rsp_err,   0);
    end
    tick();
    PREADY = 1'b1;
    sample();
    tick();
    PREADY = 1'b0;
    sample();
    check("stuck.rsp_valid", rsp_valid, 1);
    check("stuck.rsp_err",   rsp_err,   0);
    check("stuck.rsp_rdata", rsp_rdata, 32'h55);
`endif

    // Reset asserted during ACCESS.
    tick();
    set_req(1, 1'b1, 32'h400, 32'h12345678);
    PREADY = 1'b0;
    sample();
    tick();
    clear_reqs();
    sample();
    tick();
    sample();
    check("rstmid.in_access", PENABLE, 1);
    #2;
    set_req(0, 1'b0, 32'h500, 32'h0);
    PRESETn = 1'b0;
    #1;
    check_all_zero("rstmid");
    tick();
    tick();
    clear_reqs();
    PRESETn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      sample();
      check("rstmid.no_rsp",  rsp_valid, 0);
      check("rstmid.no_psel", PSEL,      0);
    end
    tick();
    set_req(0, 1'b0, 32'h600, 32'h0);
    set_req(1, 1'b0, 32'h700, 32'h0);
    PREADY = 1'b1;
    sample();
    check("rstmid.first_grant", req_ready, 3'b001);
    tick();
    clear_reqs();
    repeat (4) tick();

    // Randomized traffic against the transaction-level model.
    do_reset();
    for (int i = 0; i < N; i++) has_cmd[i] = 1'b0;
    last_g   = N - 1;
    busy     = 1'b0;
    rsp_due  = 1'b0;
    zero_cnt = 0;
    for (int c = 0; c < 600; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (!has_cmd[i] && $urandom_range(0, 3) == 0) begin
          has_cmd[i]     = 1'b1;
          cmds[i].write  = 1'($urandom_range(0, 1));
          cmds[i].addr   = $urandom;
          cmds[i].wdata  = $urandom;
        end
        req_valid[i]          = has_cmd[i];
        req_write[i]          = cmds[i].write;
        req_addr[i*AW +: AW]  = cmds[i].addr;
        req_wdata[i*DW +: DW] = cmds[i].wdata;
      end
      PREADY = ($urandom_range(0, 2) != 0);
      PRDATA = slave_data(PADDR);
      sample();

      check("rnd.rsp_valid", rsp_valid, rsp_due);
      if (rsp_due) begin
        check("rnd.rsp_id",    rsp_id,    due_id);
        check("rnd.rsp_rdata", rsp_rdata, due_rdata);
        check("rnd.rsp_err",   rsp_err,   due_err);
      end
      next_due = 1'b0;

      if (!busy) begin
        exp_ready = '0;
        g = -1;
        for (int s = 1; s <= N; s++) begin
          if (g < 0 && has_cmd[(last_g + s) % N]) g = (last_g + s) % N;
        end
        if (g >= 0) exp_ready = onehot(g);
        check("rnd.ready",   req_ready, exp_ready);
        check("rnd.idle_psel", PSEL,    0);
        check("rnd.idle_pen",  PENABLE, 0);
        if (g >= 0) begin
          busy     = 1'b1;
          t_acc    = cyc;
          cur      = cmds[g];
          cur_id   = g;
          last_g   = g;
          zero_cnt = 0;
        end
      end else begin
        check("rnd.busy_ready", req_ready, 0);
        check("rnd.psel",       PSEL,      1);
        check("rnd.penable",    PENABLE,   (cyc - t_acc) >= 2);
        check("rnd.paddr",      PADDR,     cur.addr);
        check("rnd.pwrite",     PWRITE,    cur.write);
        check("rnd.pwdata",     PWDATA,    cur.wdata);
        if ((cyc - t_acc) >= 2) begin
          if (PREADY) begin
            busy      = 1'b0;
            next_due  = 1'b1;
            due_id    = cur_id;
            due_err   = 1'b0;
            due_rdata = cur.write ? '0 : slave_data(cur.addr);
          end else begin
            zero_cnt++;
`ifdef APB_ARB_TIMEOUT_EN
            if (zero_cnt == TMO) begin
              busy      = 1'b0;
              next_due  = 1'b1;
              due_id    = cur_id;
              due_err   = 1'b1;
              due_rdata = '0;
            end
`endif
          end
        end
      end
      rsp_due = next_due;
      for (int i = 0; i < N; i++) if (req_ready[i]) has_cmd[i] = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
